led_row_scanner: RTL and testbench
==================================

LED_ROW_SCANNER -- requirements
Module: led_row_scanner

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ROWS, default 32: number of sink rows; legal range 2..64.
REQ-003 Parameter BLANK_CYC, default 2: all-off clocks between rows; legal range 0..15.
REQ-004 Parameter TIMEOUT_CYC, default 1023: clocks without a sync edge before loss is declared; legal range 16..65535.
REQ-005 Parameter SINK_ACT_HIGH, default 1: 1 = active sink bit is 1; 0 = output inverted.
REQ-006 i_CLK  in  1  system clock, 10.23 MHz nominal.
REQ-007 i_RESET  in  1  synchronous active-high reset.
REQ-008 i_TOGGLE_SYNC  in  1  asynchronous row-advance toggle; each edge (rise or fall) advances one row.
REQ-009 i_HEAD_FLAG  in  1  asynchronous; when high at a sync edge, the row index becomes 0.
REQ-010 i_ENABLE  in  1  scan enable.
REQ-011 o_LED_SINK  out  ROWS  one-hot row sink, polarity per SINK_ACT_HIGH.
REQ-012 o_ROW_IDX  out  clog2(ROWS)  current row index.
REQ-013 o_FRAME_START  out  1  one-cycle pulse when row 0 starts driving.
REQ-014 o_SYNC_LOST  out  1  high while in LOST.
REQ-015 o_OVERRUN  out  1  sticky; index wrapped without a head flag.

Function
REQ-016 Both asynchronous inputs SHALL pass through a 2-flop synchroniser; sync_edge = XOR of the synchronised level and its 1-cycle-delayed copy.
REQ-017 The FSM SHALL have four states: IDLE, BLANK, DRIVE, LOST.
REQ-018 On a sync_edge at clock k, the index SHALL update at k as follows: 0 if the head flag is high; otherwise idx+1; if idx = ROWS-1 without a head flag, the index wraps to 0 and o_OVERRUN is set.
REQ-019 The index update at clock k SHALL also set o_LED_SINK to all-off and enter BLANK.
REQ-020 After BLANK_CYC clocks in BLANK, the FSM SHALL enter DRIVE and o_LED_SINK SHALL equal one-hot(idx), so the new row drives at k+BLANK_CYC+1.
REQ-021 If BLANK_CYC = 0, the FSM SHALL skip BLANK and drive the new row at k+1.
REQ-022 A sync_edge during BLANK SHALL re-apply REQ-018 and restart the blank count.
REQ-023 o_FRAME_START SHALL pulse for exactly one clock on entering DRIVE with idx = 0.
REQ-024 The idle counter SHALL clear on every sync_edge and saturate at TIMEOUT_CYC.
REQ-025 When the idle counter reaches TIMEOUT_CYC in BLANK or DRIVE, the FSM SHALL enter LOST: sinks all-off and o_SYNC_LOST = 1.
REQ-026 LOST SHALL exit only on a sync_edge with the head flag high, to BLANK with idx = 0; edges without the head flag are ignored.
REQ-027 i_ENABLE low SHALL force IDLE on the next clock: sinks all-off, idx = 0, idle counter cleared. o_OVERRUN is not cleared.
REQ-028 In IDLE, the first sync_edge with i_ENABLE high SHALL apply REQ-018 and enter BLANK.
REQ-029 o_OVERRUN SHALL clear on a head-flag edge or on reset; a simultaneous wrap and head resolves as head, with o_OVERRUN not set.
REQ-030 o_LED_SINK SHALL be registered, with no combinational path from any input.

Reset
REQ-031 Reset SHALL set: state IDLE, idx 0, sinks all-off (polarity-correct), o_FRAME_START 0, o_SYNC_LOST 0, o_OVERRUN 0, synchroniser flops 0, counters 0.
REQ-032 Reset asserted mid-scan SHALL take effect at the next clock edge, regardless of state.

Structure
REQ-033 Package led_scan_pkg SHALL hold the state enum and the localparam index-width function.
REQ-034 Sub-module led_sync_edge SHALL contain the synchroniser and the edge detect, producing sync_edge and the synchronised head flag.

Verification
REQ-035 ROWS=8, BLANK_CYC=2: head edge, then 3 edges spaced 20 clks -> idx 0,1,2,3; sinks 0x01,0x02,0x04,0x08, each preceded by exactly 2 all-off clks.
REQ-036 ROWS=8: 9 edges with no head -> idx wraps 7->0, o_OVERRUN=1; next head edge -> o_OVERRUN=0.
REQ-037 TIMEOUT_CYC=16: no edges for 16 clks -> o_SYNC_LOST=1, sinks 0; non-head edge -> no change; head edge -> row 0 driven, o_FRAME_START pulse.
REQ-038 Edge arrives 1 clk into BLANK -> blank restarts and the later index is driven; no intermediate row is ever driven.
REQ-039 SINK_ACT_HIGH=0, ROWS=4, idx 2 -> o_LED_SINK=4'b1011; reset asserted in DRIVE -> 4'b1111 next clk.
REQ-040 i_ENABLE dropped mid-row -> IDLE next clk with sinks off; re-enabled and head edge -> row 0 driven.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED row scanner.
// Holds the scanner FSM state type and the row-index width helper.
package led_scan_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBlank,
      StDrive,
      StLost
   } scan_state_e;

   function automatic int unsigned idx_width(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/led_sync_edge.sv
// Two-flop synchroniser for the row toggle and head flag.
// Produces a one-clock pulse on either toggle edge, plus the aligned head level.
module led_sync_edge (
   input  logic i_CLK,
   input  logic i_RESET,
   input  logic i_TOGGLE_SYNC,
   input  logic i_HEAD_FLAG,
   output logic o_SYNC_EDGE,
   output logic o_HEAD_SYNC
);

   // [1] is the synchronised toggle level, [2] its one-clock-delayed copy
   logic [2:0] tog_q;
   logic [1:0] head_q;

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         tog_q  <= '0;
         head_q <= '0;
      end else begin
         tog_q  <= {tog_q[1:0], i_TOGGLE_SYNC};
         head_q <= {head_q[0], i_HEAD_FLAG};
      end
   end

   assign o_SYNC_EDGE = tog_q[2] ^ tog_q[1];
   assign o_HEAD_SYNC = head_q[1];

endmodule

// File: rtl/led_row_scanner.sv
// LED row scanner: advances a one-hot row sink on every toggle edge with blanking,
// loss-of-sync detection and a sticky overrun flag for wraps without a head flag.
module led_row_scanner
   import led_scan_pkg::*;
#(
   parameter int unsigned ROWS          = 32,
   parameter int unsigned BLANK_CYC     = 2,
   parameter int unsigned TIMEOUT_CYC   = 1023,
   parameter bit          SINK_ACT_HIGH = 1'b1
) (
   input  logic                         i_CLK,
   input  logic                         i_RESET,
   input  logic                         i_TOGGLE_SYNC,
   input  logic                         i_HEAD_FLAG,
   input  logic                         i_ENABLE,
   output logic [ROWS-1:0]              o_LED_SINK,
   output logic [idx_width(ROWS)-1:0]   o_ROW_IDX,
   output logic                         o_FRAME_START,
   output logic                         o_SYNC_LOST,
   output logic                         o_OVERRUN
);

   localparam int unsigned     IdxW       = idx_width(ROWS);
   localparam int unsigned     CntW       = 16;
   localparam logic [ROWS-1:0] SinkOff    = {ROWS{!SINK_ACT_HIGH}};
   localparam logic [3:0]      BlankLast  = 4'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);
   localparam logic [IdxW-1:0] RowLast    = IdxW'(ROWS - 1);

   scan_state_e     state_q;
   logic [IdxW-1:0] idx_q;
   logic [ROWS-1:0] sink_q;
   logic [3:0]      blank_q;
   logic [CntW-1:0] idle_q;
   logic            frame_q;
   logic            lost_q;
   logic            ovr_q;

   logic            sync_edge;
   logic            head_sync;
   logic            accept;
   logic            wrap;
   logic [IdxW-1:0] idx_next;

   function automatic logic [ROWS-1:0] row_sink(input logic [IdxW-1:0] idx);
      logic [ROWS-1:0] onehot;
      onehot      = '0;
      onehot[idx] = 1'b1;
      return onehot ^ SinkOff;
   endfunction

   led_sync_edge u_sync (
      .i_CLK         (i_CLK),
      .i_RESET       (i_RESET),
      .i_TOGGLE_SYNC (i_TOGGLE_SYNC),
      .i_HEAD_FLAG   (i_HEAD_FLAG),
      .o_SYNC_EDGE   (sync_edge),
      .o_HEAD_SYNC   (head_sync)
   );

   // A head flag wins over a simultaneous wrap
   always_comb begin
      idx_next = idx_q + 1'b1;
      wrap     = 1'b0;
      if (head_sync) begin
         idx_next = '0;
      end else if (idx_q == RowLast) begin
         idx_next = '0;
         wrap     = 1'b1;
      end
   end

   // While lost, only a head-flag edge re-acquires the scan
   assign accept = sync_edge && ((state_q != StLost) || head_sync);

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state_q <= StIdle;
         idx_q   <= '0;
         sink_q  <= SinkOff;
         blank_q <= '0;
         idle_q  <= '0;
         frame_q <= 1'b0;
         lost_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (!i_ENABLE) begin
         state_q <= StIdle;
         idx_q   <= '0;
         sink_q  <= SinkOff;
         blank_q <= '0;
         idle_q  <= '0;
         frame_q <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         if (sync_edge || (state_q == StIdle)) begin
            idle_q <= '0;
         end else if (idle_q != TimeoutVal) begin
            idle_q <= idle_q + 1'b1;
         end

         if (accept) begin
            idx_q   <= idx_next;
            blank_q <= '0;
            lost_q  <= 1'b0;
            if (head_sync) begin
               ovr_q <= 1'b0;
            end else if (wrap) begin
               ovr_q <= 1'b1;
            end
            if (BLANK_CYC == 0) begin
               state_q <= StDrive;
               sink_q  <= row_sink(idx_next);
               frame_q <= (idx_next == '0);
            end else begin
               state_q <= StBlank;
               sink_q  <= SinkOff;
            end
         end else begin
            unique case (state_q)
               StBlank: begin
                  if (idle_q == TimeoutVal) begin
                     state_q <= StLost;
                     sink_q  <= SinkOff;
                     lost_q  <= 1'b1;
                  end else if (blank_q == BlankLast) begin
                     state_q <= StDrive;
                     sink_q  <= row_sink(idx_q);
                     frame_q <= (idx_q == '0);
                  end else begin
                     blank_q <= blank_q + 1'b1;
                  end
               end
               StDrive: begin
                  if (idle_q == TimeoutVal) begin
                     state_q <= StLost;
                     sink_q  <= SinkOff;
                     lost_q  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_LED_SINK    = sink_q;
   assign o_ROW_IDX     = idx_q;
   assign o_FRAME_START = frame_q;
   assign o_SYNC_LOST   = lost_q;
   assign o_OVERRUN     = ovr_q;

endmodule

// File: tb/tb_led_row_scanner.sv
// Bench for led_row_scanner: three parameterisations share one stimulus stream and are
// compared every cycle against a timestamp-based reference, plus directed vectors.
module tb_led_row_scanner;

   localparam int ND   = 3;
   localparam int MAXC = 20000;
   localparam int MIdle = 0, MBlank = 1, MDrive = 2, MLost = 3;

   logic clk = 1'b0;
   logic rst, tog, head, en;

   logic [7:0] sink_a;  logic [2:0] idx_a;  logic fs_a, lost_a, ovr_a;
   logic [3:0] sink_b;  logic [1:0] idx_b;  logic fs_b, lost_b, ovr_b;
   logic [7:0] sink_c;  logic [2:0] idx_c;  logic fs_c, lost_c, ovr_c;

   always #5 clk = ~clk;

   led_row_scanner #(.ROWS(8), .BLANK_CYC(2), .TIMEOUT_CYC(1023), .SINK_ACT_HIGH(1'b1)) u_a (
      .i_CLK(clk), .i_RESET(rst), .i_TOGGLE_SYNC(tog), .i_HEAD_FLAG(head), .i_ENABLE(en),
      .o_LED_SINK(sink_a), .o_ROW_IDX(idx_a), .o_FRAME_START(fs_a), .o_SYNC_LOST(lost_a),
      .o_OVERRUN(ovr_a));

   led_row_scanner #(.ROWS(4), .BLANK_CYC(0), .TIMEOUT_CYC(16), .SINK_ACT_HIGH(1'b0)) u_b (
      .i_CLK(clk), .i_RESET(rst), .i_TOGGLE_SYNC(tog), .i_HEAD_FLAG(head), .i_ENABLE(en),
      .o_LED_SINK(sink_b), .o_ROW_IDX(idx_b), .o_FRAME_START(fs_b), .o_SYNC_LOST(lost_b),
      .o_OVERRUN(ovr_b));

   led_row_scanner #(.ROWS(8), .BLANK_CYC(3), .TIMEOUT_CYC(16), .SINK_ACT_HIGH(1'b1)) u_c (
      .i_CLK(clk), .i_RESET(rst), .i_TOGGLE_SYNC(tog), .i_HEAD_FLAG(head), .i_ENABLE(en),
      .o_LED_SINK(sink_c), .o_ROW_IDX(idx_c), .o_FRAME_START(fs_c), .o_SYNC_LOST(lost_c),
      .o_OVERRUN(ovr_c));

   int nchk = 0;
   int nerr = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      nchk++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic int rows_of(input int d);
      return (d == 1) ? 4 : 8;
   endfunction
   function automatic int blank_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
   endfunction
   function automatic int to_of(input int d);
      return (d == 0) ? 1023 : 16;
   endfunction

   // Reference: sampled input history plus per-DUT timestamps of last edge and last accept
   bit tog_h  [0:MAXC-1];
   bit head_h [0:MAXC-1];
   int cyc = 0;
   int m_mode [ND];
   int m_idx  [ND];
   bit m_ovr  [ND];
   bit m_fs   [ND];
   int m_acc  [ND];
   int m_last [ND];

   task automatic model_step(input int d, input bit e, input bit h);
      if (rst) begin
         m_mode[d] = MIdle; m_idx[d] = 0; m_ovr[d] = 0; m_fs[d] = 0;
      end else if (!en) begin
         m_mode[d] = MIdle; m_idx[d] = 0; m_fs[d] = 0;
      end else begin
         m_fs[d] = 0;
         if (e) m_last[d] = cyc;
         if (e && (m_mode[d] != MLost || h)) begin
            if (h) begin
               m_idx[d] = 0; m_ovr[d] = 0;
            end else begin
               m_idx[d] = (m_idx[d] + 1) % rows_of(d);
               if (m_idx[d] == 0) m_ovr[d] = 1;
            end
            m_acc[d] = cyc;
            if (blank_of(d) == 0) begin
               m_mode[d] = MDrive; m_fs[d] = (m_idx[d] == 0);
            end else begin
               m_mode[d] = MBlank;
            end
         end else if ((m_mode[d] == MBlank || m_mode[d] == MDrive) &&
                      (cyc - m_last[d] > to_of(d))) begin
            m_mode[d] = MLost;
         end else if (m_mode[d] == MBlank && (cyc - m_acc[d] == blank_of(d))) begin
            m_mode[d] = MDrive; m_fs[d] = (m_idx[d] == 0);
         end
      end
   endtask

   always @(posedge clk) begin : model
      bit e, h;
      if (cyc >= MAXC) begin
         $display("FAIL cycle budget: got %0d expected below %0d", cyc, MAXC);
         $fatal(1, "cycle budget exceeded");
      end
      e = 1'b0; h = 1'b0;
      if (cyc >= 3) begin
         e = tog_h[cyc-2] ^ tog_h[cyc-3];
         h = head_h[cyc-2];
      end
      if (rst) begin
         tog_h[cyc] = 1'b0; head_h[cyc] = 1'b0;
         if (cyc >= 1) begin tog_h[cyc-1] = 1'b0; head_h[cyc-1] = 1'b0; end
         if (cyc >= 2) begin tog_h[cyc-2] = 1'b0; head_h[cyc-2] = 1'b0; end
      end else begin
         tog_h[cyc] = tog; head_h[cyc] = head;
      end
      for (int d = 0; d < ND; d++) model_step(d, e, h);
      cyc++;
   end

   function automatic logic [63:0] exp_sink(input int d);
      logic [63:0] v, mask;
      mask = (64'd1 << rows_of(d)) - 64'd1;
      v = (m_mode[d] == MDrive) ? (64'd1 << m_idx[d]) : 64'd0;
      if (d == 1) v = ~v & mask;
      return v;
   endfunction

   function automatic logic [63:0] dut_sink(input int d);
      case (d)
         0: return 64'(sink_a);
         1: return 64'(sink_b);
         default: return 64'(sink_c);
      endcase
   endfunction
   function automatic logic [63:0] dut_idx(input int d);
      case (d)
         0: return 64'(idx_a);
         1: return 64'(idx_b);
         default: return 64'(idx_c);
      endcase
   endfunction
   function automatic logic [2:0] dut_flags(input int d);
      case (d)
         0: return {fs_a, lost_a, ovr_a};
         1: return {fs_b, lost_b, ovr_b};
         default: return {fs_c, lost_c, ovr_c};
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < ND; d++) begin
            logic [2:0] f;
            f = dut_flags(d);
            check($sformatf("model d%0d sink", d), dut_sink(d), exp_sink(d));
            check($sformatf("model d%0d idx", d), dut_idx(d), 64'(m_idx[d]));
            check($sformatf("model d%0d frame", d), 64'(f[2]), 64'(m_fs[d]));
            check($sformatf("model d%0d lost", d), 64'(f[1]), 64'(m_mode[d] == MLost));
            check($sformatf("model d%0d ovr", d), 64'(f[0]), 64'(m_ovr[d]));
         end
      end
   end

   task automatic pulse_edge(input bit h);
      @(negedge clk);
      head = h;
      tog  = ~tog;
   endtask

   // Waits for A to go dark, then counts dark cycles until a row drives
   task automatic measure_a(output int offc, output logic [7:0] drv);
      int n;
      offc = 0; n = 0;
      while (sink_a != 8'h00 && n < 10) begin @(negedge clk); n++; end
      while (sink_a == 8'h00 && n < 40) begin @(negedge clk); n++; offc++; end
      drv = sink_a;
   endtask

   typedef struct {
      bit         head;
      int         idx;
      logic [7:0] sink;
      bit         ovr;
   } vec_t;

   initial begin : stim
      vec_t       tbl [11];
      int         offc, gap, n;
      logic [7:0] drv;

      tbl[0]  = '{1'b1, 0, 8'h01, 1'b0};
      tbl[1]  = '{1'b0, 1, 8'h02, 1'b0};
      tbl[2]  = '{1'b0, 2, 8'h04, 1'b0};
      tbl[3]  = '{1'b0, 3, 8'h08, 1'b0};
      tbl[4]  = '{1'b0, 4, 8'h10, 1'b0};
      tbl[5]  = '{1'b0, 5, 8'h20, 1'b0};
      tbl[6]  = '{1'b0, 6, 8'h40, 1'b0};
      tbl[7]  = '{1'b0, 7, 8'h80, 1'b0};
      tbl[8]  = '{1'b0, 0, 8'h01, 1'b1};
      tbl[9]  = '{1'b1, 0, 8'h01, 1'b0};
      tbl[10] = '{1'b0, 1, 8'h02, 1'b0};

      rst = 1'b1; tog = 1'b0; head = 1'b0; en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;
      check("reset sink_a", 64'(sink_a), 64'h00);
      check("reset sink_b", 64'(sink_b), 64'hF);
      check("reset idx_a", 64'(idx_a), 64'd0);
      repeat (3) @(negedge clk);

      // Row sequence, wrap with overrun, head clears overrun
      for (int i = 0; i < 11; i++) begin
         pulse_edge(tbl[i].head);
         measure_a(offc, drv);
         check($sformatf("tbl%0d sink", i), 64'(drv), 64'(tbl[i].sink));
         check($sformatf("tbl%0d idx", i), 64'(idx_a), 64'(tbl[i].idx));
         check($sformatf("tbl%0d ovr", i), 64'(ovr_a), 64'(tbl[i].ovr));
         if (i > 0) check($sformatf("tbl%0d blank", i), 64'(offc), 64'd2);
         repeat (14) @(negedge clk);
      end

      // Second edge one clock into blank restarts it; row 2 never drives
      pulse_edge(1'b0);
      pulse_edge(1'b0);
      measure_a(offc, drv);
      check("restart sink", 64'(drv), 64'h08);
      check("restart blank", 64'(offc), 64'd3);
      check("restart idx", 64'(idx_a), 64'd3);

      // Active-low sinks on B, then reset while driving
      pulse_edge(1'b1);
      repeat (3) @(negedge clk);
      pulse_edge(1'b0);
      repeat (3) @(negedge clk);
      pulse_edge(1'b0);
      repeat (5) @(negedge clk);
      check("b row2 sink", 64'(sink_b), 64'hB);
      check("b row2 idx", 64'(idx_b), 64'd2);
      rst = 1'b1; tog = 1'b0; head = 1'b0;
      @(negedge clk);
      check("b reset sink", 64'(sink_b), 64'hF);
      check("b reset idx", 64'(idx_b), 64'd0);
      check("a reset sink", 64'(sink_a), 64'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Enable dropped mid-row, then re-acquire with a head edge
      pulse_edge(1'b1);
      measure_a(offc, drv);
      pulse_edge(1'b0);
      measure_a(offc, drv);
      check("en row1", 64'(drv), 64'h02);
      repeat (3) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("en off sink", 64'(sink_a), 64'h00);
      check("en off idx", 64'(idx_a), 64'd0);
      en = 1'b1;
      repeat (2) @(negedge clk);
      pulse_edge(1'b1);
      measure_a(offc, drv);
      check("en head sink", 64'(drv), 64'h01);
      check("en head frame", 64'(fs_a), 64'd1);
      @(negedge clk);
      check("en frame drop", 64'(fs_a), 64'd0);

      // Loss of sync on C, ignored plain edge, head recovery
      n = 0;
      while (lost_c !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("c lost", 64'(lost_c), 64'd1);
      check("c lost sink", 64'(sink_c), 64'h00);
      pulse_edge(1'b0);
      repeat (6) @(negedge clk);
      check("c lost plain edge", 64'(lost_c), 64'd1);
      check("c lost plain sink", 64'(sink_c), 64'h00);
      pulse_edge(1'b1);
      n = 0;
      while (sink_c == 8'h00 && n < 20) begin @(negedge clk); n++; end
      check("c recover sink", 64'(sink_c), 64'h01);
      check("c recover frame", 64'(fs_c), 64'd1);
      check("c recover lost", 64'(lost_c), 64'd0);

      // Random edges, gaps, head flags, enable drops and resets against the reference
      for (int s = 0; s < 150; s++) begin
         gap = $urandom_range(1, 24);
         repeat (gap) @(negedge clk);
         if ($urandom_range(0, 29) == 0) begin
            rst = 1'b1; tog = 1'b0;
            @(negedge clk);
            rst = 1'b0;
         end else if ($urandom_range(0, 14) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            en = 1'b1;
         end
         head = ($urandom_range(0, 3) == 0);
         tog  = ~tog;
      end
      repeat (30) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
